complex_div: RTL and testbench

- Sequential fixed-point complex divider: computes q = n / d for n = n_r + j·n_i and d = d_r + j·d_i.
- Inverse counterpart of the FFT datapath complex multiplier; used for IFFT normalisation, equalisation and channel correction.
- Computes q = ((n_r·d_r + n_i·d_i) + j(n_i·d_r − n_r·d_i)) / (d_r² + d_i²).
- Two restoring dividers run in parallel; signed Q1.15 operands and results; valid/ready on both sides.

---
 rtl/complex_div_if.sv | 36 +++
 rtl/complex_div.sv | 206 ++++++++++++++++++++
 tb/tb_complex_div.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/complex_div_if.sv
`timescale 1ns/1ps
// complex_div_if: operand/result handshake bundle for the complex divider.
//   in_valid/in_ready   operand-side handshake
//   n_r, n_i            numerator real/imag, signed Q1.(WL-1)
//   d_r, d_i            denominator real/imag, signed Q1.(WL-1)
//   out_valid/out_ready result-side handshake
//   q_r, q_i            quotient real/imag, signed Q1.(WL-1)
//   ovf                 a quotient component saturated
//   dz                  denominator was zero
// master: producer/consumer side, slave: divider side.
interface complex_div_if #(
    parameter int unsigned WL = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [WL-1:0] n_r;
    logic [WL-1:0] n_i;
    logic [WL-1:0] d_r;
    logic [WL-1:0] d_i;
    logic          out_valid;
    logic          out_ready;
    logic [WL-1:0] q_r;
    logic [WL-1:0] q_i;
    logic          ovf;
    logic          dz;

    modport master (
        output in_valid, n_r, n_i, d_r, d_i, out_ready,
        input  in_ready, out_valid, q_r, q_i, ovf, dz
    );

    modport slave (
        input  in_valid, n_r, n_i, d_r, d_i, out_ready,
        output in_ready, out_valid, q_r, q_i, ovf, dz
    );
endinterface

// File: rtl/complex_div.sv
`timescale 1ns/1ps
// complex_div: sequential fixed-point complex divider q = n / d.
//   q = ((n_r*d_r + n_i*d_i) + j(n_i*d_r - n_r*d_i)) / (d_r^2 + d_i^2)
// Two restoring dividers (real/imag) iterate in parallel, one bit per cycle.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  complex_div_if.slave (operand/result handshakes, q_r/q_i, ovf, dz)
// Optional build macro COMPLEX_DIV_ROUND_EN: one extra iteration and
// round-half-away-from-zero instead of truncation (latency WL+4 vs WL+3).
module complex_div #(
    parameter int unsigned WL = 16
) (
    input  logic         clk,
    input  logic         rst,
    complex_div_if.slave bus
);

`ifdef COMPLEX_DIV_ROUND_EN
    localparam int unsigned RB = 1;
`else
    localparam int unsigned RB = 0;
`endif
    localparam int unsigned PW = 2 * WL;     // product / denominator width
    localparam int unsigned NW = 2 * WL + 1; // signed numerator width
    localparam int unsigned K  = WL + 1 + RB; // quotient bits produced
    localparam int unsigned MW = WL + 2;     // magnitude width after rounding
    localparam int unsigned CW = $clog2(K);

    localparam logic [CW-1:0] LastIt = CW'(K - 1);
    localparam logic [CW-1:0] CntOne = CW'(1);
    localparam logic [WL-1:0] MaxVal = {1'b0, {(WL-1){1'b1}}};
    localparam logic [WL-1:0] MinVal = {1'b1, {(WL-1){1'b0}}};
    localparam logic [WL-1:0] OneW   = WL'(1);
    localparam logic [MW-1:0] PosLim = MW'(MaxVal);
    localparam logic [MW-1:0] NegLim = MW'(MinVal);

    typedef enum logic [2:0] {StIdle, StMul, StDiv, StSign, StDone} state_t;

    state_t        state_q, state_d;
    logic [WL-1:0] nr_q, ni_q, dr_q, di_q;
    logic [PW-1:0] den_q, rem_r_q, rem_i_q;
    logic [K-1:0]  sh_r_q, sh_i_q;   // dividend low bits shift out, quotient bits shift in
    logic          big_r_q, big_i_q; // quotient would not fit in K bits
    logic          neg_r_q, neg_i_q, dzi_q;
    logic [CW-1:0] cnt_q;
    logic [WL-1:0] q_r_q, q_i_q;
    logic          ovf_q, dz_q;

    logic signed [PW-1:0] p_rr, p_ii, p_ir, p_ri, s_r, s_i;
    logic signed [NW-1:0] num_r, num_i;
    logic [PW-1:0]        den, mag_r, mag_i, rem_r_nx, rem_i_nx;
    logic [PW:0]          t_r, t_i;
    logic                 bit_r, bit_i;
    logic [MW-1:0]        m_r, m_i;
    logic [WL:0]          sat_r, sat_i;

    // Returns {ovf, value} for a sign/magnitude pair; big forces saturation.
    function automatic logic [WL:0] saturate(input logic [MW-1:0] mag, input logic neg,
                                             input logic big);
        logic [WL-1:0] low;
        logic [WL:0]   r;
        low = mag[WL-1:0];
        if (!neg) begin
            if (big || mag > PosLim) r = {1'b1, MaxVal};
            else                     r = {1'b0, low};
        end else begin
            // Magnitude 2^(WL-1) negates to exactly -1.0, which is representable.
            if (big || mag > NegLim) r = {1'b1, MinVal};
            else                     r = {1'b0, (~low) + OneW};
        end
        return r;
    endfunction

    // Full-precision products and magnitudes.
    always_comb begin
        p_rr  = PW'($signed(nr_q)) * PW'($signed(dr_q));
        p_ii  = PW'($signed(ni_q)) * PW'($signed(di_q));
        p_ir  = PW'($signed(ni_q)) * PW'($signed(dr_q));
        p_ri  = PW'($signed(nr_q)) * PW'($signed(di_q));
        s_r   = PW'($signed(dr_q)) * PW'($signed(dr_q));
        s_i   = PW'($signed(di_q)) * PW'($signed(di_q));
        num_r = {p_rr[PW-1], p_rr} + {p_ii[PW-1], p_ii};
        num_i = {p_ir[PW-1], p_ir} - {p_ri[PW-1], p_ri};
        den   = s_r + s_i;
        mag_r = num_r[NW-1] ? PW'(-num_r) : num_r[PW-1:0];
        mag_i = num_i[NW-1] ? PW'(-num_i) : num_i[PW-1:0];
    end

    // One restoring step per component.
    always_comb begin
        t_r      = {rem_r_q, sh_r_q[K-1]};
        t_i      = {rem_i_q, sh_i_q[K-1]};
        bit_r    = t_r >= {1'b0, den_q};
        bit_i    = t_i >= {1'b0, den_q};
        rem_r_nx = bit_r ? PW'(t_r - {1'b0, den_q}) : t_r[PW-1:0];
        rem_i_nx = bit_i ? PW'(t_i - {1'b0, den_q}) : t_i[PW-1:0];
    end

    // Final magnitude (optionally rounded) and saturation.
    always_comb begin
`ifdef COMPLEX_DIV_ROUND_EN
        m_r = MW'(sh_r_q[K-1:1]) + MW'(sh_r_q[0]);
        m_i = MW'(sh_i_q[K-1:1]) + MW'(sh_i_q[0]);
`else
        m_r = MW'(sh_r_q);
        m_i = MW'(sh_i_q);
`endif
        sat_r = saturate(m_r, neg_r_q, big_r_q);
        sat_i = saturate(m_i, neg_i_q, big_i_q);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.in_valid) state_d = StMul;
            StMul:   state_d = StDiv;
            StDiv:   if (cnt_q == LastIt) state_d = StSign;
            StSign:  state_d = StDone;
            StDone:  if (bus.out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            nr_q    <= '0;
            ni_q    <= '0;
            dr_q    <= '0;
            di_q    <= '0;
            den_q   <= '0;
            rem_r_q <= '0;
            rem_i_q <= '0;
            sh_r_q  <= '0;
            sh_i_q  <= '0;
            big_r_q <= 1'b0;
            big_i_q <= 1'b0;
            neg_r_q <= 1'b0;
            neg_i_q <= 1'b0;
            dzi_q   <= 1'b0;
            cnt_q   <= '0;
            q_r_q   <= '0;
            q_i_q   <= '0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        nr_q  <= bus.n_r;
                        ni_q  <= bus.n_i;
                        dr_q  <= bus.d_r;
                        di_q  <= bus.d_i;
                        ovf_q <= 1'b0;
                        dz_q  <= 1'b0;
                    end
                end
                StMul: begin
                    // Dividend is |num| << (K-2); its bits above the K quotient bits
                    // are |num| >> 2 and seed the remainder.
                    den_q   <= den;
                    rem_r_q <= mag_r >> 2;
                    rem_i_q <= mag_i >> 2;
                    sh_r_q  <= {mag_r[1:0], {(K-2){1'b0}}};
                    sh_i_q  <= {mag_i[1:0], {(K-2){1'b0}}};
                    big_r_q <= (mag_r >> 2) >= den;
                    big_i_q <= (mag_i >> 2) >= den;
                    neg_r_q <= num_r[NW-1];
                    neg_i_q <= num_i[NW-1];
                    dzi_q   <= (den == '0);
                    cnt_q   <= '0;
                end
                StDiv: begin
                    rem_r_q <= rem_r_nx;
                    rem_i_q <= rem_i_nx;
                    sh_r_q  <= {sh_r_q[K-2:0], bit_r};
                    sh_i_q  <= {sh_i_q[K-2:0], bit_i};
                    cnt_q   <= cnt_q + CntOne;
                end
                StSign: begin
                    if (dzi_q) begin
                        q_r_q <= nr_q[WL-1] ? MinVal : MaxVal;
                        q_i_q <= ni_q[WL-1] ? MinVal : MaxVal;
                        ovf_q <= 1'b0;
                    end else begin
                        q_r_q <= sat_r[WL-1:0];
                        q_i_q <= sat_i[WL-1:0];
                        ovf_q <= sat_r[WL] | sat_i[WL];
                    end
                    dz_q <= dzi_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.q_r       = q_r_q;
    assign bus.q_i       = q_i_q;
    assign bus.ovf       = ovf_q;
    assign bus.dz        = dz_q;

endmodule

// File: tb/tb_complex_div.sv
`timescale 1ns/1ps
// tb_complex_div: randomized and directed checks of complex_div against an
// arithmetic reference model (plain integer division of the complex formula).
module tb_complex_div;
    localparam int WL = 16;
`ifdef COMPLEX_DIV_ROUND_EN
    localparam int LAT = WL + 4;
`else
    localparam int LAT = WL + 3;
`endif

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    complex_div_if #(.WL(WL)) bus ();

    complex_div #(.WL(WL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns {ovf, q} for one component.
    function automatic logic [16:0] ref_comp(input longint num, input longint den,
                                             input logic [15:0] ncomp);
        longint mag;
        longint qm;
        if (den == 0) return {1'b0, ncomp[15] ? 16'h8000 : 16'h7FFF};
        mag = (num < 0) ? -num : num;
`ifdef COMPLEX_DIV_ROUND_EN
        qm = ((mag * 65536) / den + 1) / 2;
`else
        qm = (mag * 32768) / den;
`endif
        if (num >= 0) begin
            if (qm > 32767) return {1'b1, 16'h7FFF};
            return {1'b0, 16'(qm)};
        end
        if (qm > 32768) return {1'b1, 16'h8000};
        return {1'b0, 16'(-qm)};
    endfunction

    task automatic start_op(input logic [15:0] nr, input logic [15:0] ni,
                            input logic [15:0] dr, input logic [15:0] di);
        int w;
        w = 0;
        while (!bus.in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        check_val("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.n_r      = nr;
        bus.n_i      = ni;
        bus.d_r      = dr;
        bus.d_i      = di;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check_val("flags_cleared", {30'd0, bus.ovf, bus.dz}, 32'd0);
    endtask

    // Call at the negedge right after the capture edge.
    task automatic wait_result(input logic [15:0] eqr, input logic [15:0] eqi,
                               input logic eov, input logic edz);
        int lat;
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check_val("latency", 32'(lat), 32'(LAT));
        check_val("q_r", 32'(bus.q_r), 32'(eqr));
        check_val("q_i", 32'(bus.q_i), 32'(eqi));
        check_val("ovf", 32'(bus.ovf), 32'(eov));
        check_val("dz", 32'(bus.dz), 32'(edz));
    endtask

    task automatic do_op(input logic [15:0] nr, input logic [15:0] ni,
                         input logic [15:0] dr, input logic [15:0] di,
                         input logic [15:0] eqr, input logic [15:0] eqi,
                         input logic eov, input logic edz);
        start_op(nr, ni, dr, di);
        wait_result(eqr, eqi, eov, edz);
        @(negedge clk);
    endtask

    task automatic ref_op(input logic [15:0] nr, input logic [15:0] ni,
                          input logic [15:0] dr, input logic [15:0] di);
        longint a, b, c, d, den;
        logic [16:0] rr, ri;
        a   = longint'($signed(nr));
        b   = longint'($signed(ni));
        c   = longint'($signed(dr));
        d   = longint'($signed(di));
        den = c * c + d * d;
        rr  = ref_comp(a * c + b * d, den, nr);
        ri  = ref_comp(b * c - a * d, den, ni);
        do_op(nr, ni, dr, di, rr[15:0], ri[15:0], rr[16] | ri[16], den == 0);
    endtask

    logic [15:0] hold_r, hold_i;

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.n_r       = '0;
        bus.n_i       = '0;
        bus.d_r       = '0;
        bus.d_i       = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_val("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_val("rst_q", {bus.q_r, bus.q_i}, 32'd0);
        check_val("rst_flags", {30'd0, bus.ovf, bus.dz}, 32'd0);

        // Directed cases with exact quotients (identical in both build variants).
        do_op(16'h2000, 16'h0000, 16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b0, 1'b0);
        do_op(16'h2000, 16'h2000, 16'h4000, 16'h4000, 16'h4000, 16'h0000, 1'b0, 1'b0);
        do_op(16'h0000, 16'h2000, 16'h4000, 16'h0000, 16'h0000, 16'h4000, 1'b0, 1'b0);
        do_op(16'hE000, 16'h0000, 16'h4000, 16'h0000, 16'hC000, 16'h0000, 1'b0, 1'b0);
        do_op(16'h4000, 16'hC000, 16'h2000, 16'h0000, 16'h7FFF, 16'h8000, 1'b1, 1'b0);
        do_op(16'hC000, 16'h0000, 16'h4000, 16'h0000, 16'h8000, 16'h0000, 1'b0, 1'b0);
        do_op(16'h1000, 16'hF000, 16'h0000, 16'h0000, 16'h7FFF, 16'h8000, 1'b0, 1'b1);
        do_op(16'h2000, 16'h0000, 16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b0, 1'b0);

        // Backpressure: result held, new operands ignored until released.
        bus.out_ready = 1'b0;
        start_op(16'hE000, 16'h1000, 16'h4000, 16'h0000);
        wait_result(16'hC000, 16'h2000, 1'b0, 1'b0);
        hold_r       = bus.q_r;
        hold_i       = bus.q_i;
        bus.n_r      = 16'h1000;
        bus.n_i      = 16'h0000;
        bus.d_r      = 16'h4000;
        bus.d_i      = 16'h0000;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_val("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check_val("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check_val("bp_q_stable", {bus.q_r, bus.q_i}, {16'hC000, 16'h2000});
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check_val("bp_release_idle", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_result(16'h2000, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);

        // Reset during DIV iteration 5 aborts the operation.
        start_op(16'h6000, 16'h0000, 16'h4000, 16'h0000);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_val("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check_val("mid_rst_q", {bus.q_r, bus.q_i}, 32'd0);
        do_op(16'hF000, 16'h0800, 16'h4000, 16'h0000, 16'hE000, 16'h1000, 1'b0, 1'b0);

        // Randomized operands; some with tiny denominators, some with zero.
        for (int i = 0; i < 40; i++) begin
            logic [15:0] a, b, c, d;
            a = 16'($urandom);
            b = 16'($urandom);
            c = 16'($urandom);
            d = 16'($urandom);
            if (i % 4 == 1) begin
                c = 16'($urandom_range(0, 511)) - 16'd256;
                d = 16'($urandom_range(0, 63));
            end
            if (i % 10 == 7) begin
                c = '0;
                d = '0;
            end
            ref_op(a, b, c, d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
